// File: rtl/subc_pkg.sv
// rtl/subc_pkg.sv - shared word, response and input-stage types for the SUBC32 scheduler
package subc_pkg;

  localparam int WORD_W   = 32;
  localparam int ID_MAX_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  // The id field is sized for the largest supported NREQ (16); the top uses the low IDW bits.
  typedef struct packed {
    word_t               diff;
    logic                ge;
    logic [ID_MAX_W-1:0] id;
  } rsp_t;

  typedef struct packed {
    word_t               a;
    word_t               b;
    logic [ID_MAX_W-1:0] id;
  } in_stage_t;

endpackage

// File: rtl/subc32.sv
// rtl/subc32.sv - 32-bit subtractor core: wx = x_a - x_b, cout = carry out (x_a >= x_b)
module SUBC32 (
  input  logic [31:0] x_a,
  input  logic [31:0] x_b,
  output logic [31:0] wx,
  output logic        cout
);

  assign {cout, wx} = {1'b0, x_a} + {1'b0, ~x_b} + 33'd1;

endmodule

// File: rtl/subc32_rr_sched_rr_arbiter.sv
// rtl/subc32_rr_sched_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  logic           w_found;
  logic [IDW-1:0] w_idx;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req[(int'(ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_idx   = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign any     = en & w_found;
  assign gnt_idx = w_idx;
  assign gnt     = any ? (NREQ'(1) << w_idx) : '0;

endmodule

// File: rtl/subc32_rr_sched.sv
// rtl/subc32_rr_sched.sv - round-robin share of one SUBC32 among NREQ requesters
// SUBC_INREG_EN adds an input register stage ahead of SUBC32 (latency 2 instead of 1).
module subc32_rr_sched
  import subc_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_diff,
  output logic                 rsp_ge,
  output logic [IDW-1:0]       rsp_id,
  output logic [CNTW-1:0]      op_cnt
);

  logic [IDW-1:0]      r_rr_ptr;
  rsp_t                r_rsp;
  logic                r_rsp_valid;
  logic [CNTW-1:0]     r_op_cnt;

  logic                w_out_free;
  logic                w_drain;
  logic                w_arb_en;
  logic [NREQ-1:0]     w_gnt;
  logic [IDW-1:0]      w_gnt_idx;
  logic                w_accept;
  logic [IDW-1:0]      w_ptr_nxt;
  word_t               w_sel_a;
  word_t               w_sel_b;
  logic [ID_MAX_W-1:0] w_gnt_id;
  word_t               w_sub_a;
  word_t               w_sub_b;
  word_t               w_sub_wx;
  logic                w_sub_cout;
  rsp_t                w_sub_rsp;
  logic                w_out_load_v;
  logic                w_unused_id;

  assign w_drain    = r_rsp_valid & rsp_ready;
  assign w_out_free = ~r_rsp_valid | rsp_ready;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_accept)
  );

  assign req_ready = w_gnt;
  assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_gnt_id  = ID_MAX_W'(w_gnt_idx);

  // One-hot grant mux; selects zero when nothing is granted.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_a = req_a[32*i +: 32];
        w_sel_b = req_b[32*i +: 32];
      end
    end
  end

`ifdef SUBC_INREG_EN
  in_stage_t r_in;
  logic      r_in_valid;
  logic      w_in_free;

  assign w_in_free    = ~r_in_valid | w_out_free;
  assign w_arb_en     = rst_n & w_in_free;
  assign w_sub_a      = r_in.a;
  assign w_sub_b      = r_in.b;
  assign w_out_load_v = r_in_valid;
  assign w_sub_rsp    = '{diff: w_sub_wx, ge: w_sub_cout, id: r_in.id};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_valid <= 1'b0;
      r_in       <= '0;
    end else if (w_in_free) begin
      r_in_valid <= w_accept;
      if (w_accept) begin
        r_in <= '{a: w_sel_a, b: w_sel_b, id: w_gnt_id};
      end
    end
  end
`else
  assign w_arb_en     = rst_n & w_out_free;
  assign w_sub_a      = w_sel_a;
  assign w_sub_b      = w_sel_b;
  assign w_out_load_v = w_accept;
  assign w_sub_rsp    = '{diff: w_sub_wx, ge: w_sub_cout, id: w_gnt_id};
`endif

  SUBC32 u_subc (
    .x_a  (w_sub_a),
    .x_b  (w_sub_b),
    .wx   (w_sub_wx),
    .cout (w_sub_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
      r_op_cnt    <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_drain) begin
        r_op_cnt <= r_op_cnt + 1'b1;
      end
      if (w_accept) begin
        r_rr_ptr <= w_ptr_nxt;
      end
      if (w_out_free) begin
        r_rsp_valid <= w_out_load_v;
        if (w_out_load_v) begin
          r_rsp <= w_sub_rsp;
        end
      end
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_diff    = r_rsp.diff;
  assign rsp_ge      = r_rsp.ge;
  assign rsp_id      = r_rsp.id[IDW-1:0];
  assign op_cnt      = r_op_cnt;
  assign w_unused_id = ^r_rsp.id;

endmodule
